// File: rtl/timebase_pkg.sv
// Shared types and defaults for the programmable timebase.
package timebase_pkg;

  localparam int unsigned CntWDef   = 28;
  localparam int unsigned DefDivDef = 100000000;  // 1 Hz tick from a 100 MHz clock
  localparam int unsigned MinDiv    = 2;          // shortest period the counter supports

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } state_e;

endpackage

// File: rtl/div_counter.sv
// Free-running modulo-N counter with sync clear, enable and a terminal-count flag.
module div_counter
  import timebase_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             term
);

  logic [CNT_W-1:0] count;

  // Flags the last count of the period, N-1.
  assign term = (count == period - CNT_W'(1));

  // Counts 0..N-1 while enabled and wraps; clear wins over enable.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= term ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/timebase_ctrl.sv
// Programmable tick generator: config handshake, run/hold/idle control and tick counting.
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int unsigned CNT_W   = CntWDef,
  parameter int unsigned DEF_DIV = DefDivDef
) (
  input  logic             CLK_100MHz,
  input  logic             CLR,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [CNT_W-1:0] CFG_DIV,
  input  logic             CFG_ONESHOT,
  input  logic             START,
  input  logic             STOP,
  output logic             TICK,
  output logic             DONE,
  output logic             BUSY,
  output logic [15:0]      TICK_CNT
);

  state_e           state;
  logic [CNT_W-1:0] period;
  logic             oneshot;
  logic             tick_q;
  logic             done_q;
  logic [15:0]      tick_cnt;

  logic             term;
  logic             run_live;
  logic             os_term;
  logic             tick_set;
  logic             cnt_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] cfg_div_eff;

  // Counter control; the one-shot terminal count overrides STOP so TICK/DONE still fire.
  always_comb begin
    run_live    = (state == StRun) && !done_q;
    os_term     = run_live && oneshot && term;
    tick_set    = run_live && term && (!STOP || oneshot);
    cnt_en      = run_live && (!STOP || os_term);
    cnt_clr     = CLR || (state == StIdle) || ((state == StHold) && STOP);
    cfg_div_eff = (CFG_DIV < CNT_W'(MinDiv)) ? CNT_W'(MinDiv) : CFG_DIV;
  end

  div_counter #(
    .CNT_W (CNT_W)
  ) u_div_counter (
    .clk    (CLK_100MHz),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .period (period),
    .term   (term)
  );

  // State machine, config capture, registered TICK/DONE and tick counting.
  always_ff @(posedge CLK_100MHz) begin
    if (CLR) begin
      state    <= StIdle;
      period   <= CNT_W'(DEF_DIV);
      oneshot  <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      tick_cnt <= '0;
    end else begin
      tick_q <= tick_set;
      done_q <= tick_set && oneshot;
      if (tick_set) begin
        tick_cnt <= tick_cnt + 16'd1;
      end
      unique case (state)
        StIdle: begin
          if (CFG_VALID) begin
            period  <= cfg_div_eff;
            oneshot <= CFG_ONESHOT;
          end
          if (START && !STOP) begin
            state    <= StRun;
            tick_cnt <= '0;
          end
        end
        StRun: begin
          // done_q marks the one-shot TICK cycle; leave on the following edge.
          if (done_q) begin
            state <= StIdle;
          end else if (STOP && !os_term) begin
            state <= StHold;
          end
        end
        StHold: begin
          if (STOP) begin
            state <= StIdle;
          end else if (START) begin
            state <= StRun;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign TICK      = tick_q;
  assign DONE      = done_q;
  assign TICK_CNT  = tick_cnt;
  assign BUSY      = (state == StRun) || (state == StHold);
  assign CFG_READY = (state == StIdle);

endmodule

// File: tb/tb_timebase_ctrl.sv
// Self-checking bench for timebase_ctrl; expectations come from counting
// "active" RUN edges: a tick follows every N-th RUN edge that is not paused.
module tb_timebase_ctrl;

  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 12;

  logic             clk = 1'b0;
  logic             CLR = 1'b0;
  logic             CFG_VALID = 1'b0;
  logic             CFG_READY;
  logic [CNT_W-1:0] CFG_DIV = '0;
  logic             CFG_ONESHOT = 1'b0;
  logic             START = 1'b0;
  logic             STOP = 1'b0;
  logic             TICK;
  logic             DONE;
  logic             BUSY;
  logic [15:0]      TICK_CNT;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  timebase_ctrl #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .CLK_100MHz  (clk),
    .CLR         (CLR),
    .CFG_VALID   (CFG_VALID),
    .CFG_READY   (CFG_READY),
    .CFG_DIV     (CFG_DIV),
    .CFG_ONESHOT (CFG_ONESHOT),
    .START       (START),
    .STOP        (STOP),
    .TICK        (TICK),
    .DONE        (DONE),
    .BUSY        (BUSY),
    .TICK_CNT    (TICK_CNT)
  );

  // One active edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int div, input logic os);
    CFG_VALID   = 1'b1;
    CFG_DIV     = CNT_W'(div);
    CFG_ONESHOT = os;
    step();
    CFG_VALID   = 1'b0;
    CFG_DIV     = '0;
    CFG_ONESHOT = 1'b0;
  endtask

  task automatic to_idle();
    START = 1'b0;
    STOP  = 1'b1;
    step();
    step();
    STOP  = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    step();
    step();
    CLR = 1'b0;
    n_tot++; if (TICK !== 1'b0) $display("FAIL reset_tick got %b want 0", TICK); else n_pass++;
    n_tot++; if (DONE !== 1'b0) $display("FAIL reset_done got %b want 0", DONE); else n_pass++;
    n_tot++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else n_pass++;
    n_tot++; if (CFG_READY !== 1'b1) $display("FAIL reset_ready got %b want 1", CFG_READY);
    else n_pass++;
    n_tot++; if (TICK_CNT !== 16'd0) $display("FAIL reset_tick_cnt got %0d want 0", TICK_CNT);
    else n_pass++;
  endtask

  // Periodic run of period n for 3n edges after START; ticks on every multiple of n.
  task automatic run_periodic(input int n);
    logic exp;
    to_idle();
    cfg(n, 1'b0);
    START = 1'b1;
    step();
    START = 1'b0;
    for (int j = 1; j <= 3 * n + 1; j++) begin
      step();
      exp = (j % n == 0);
      n_tot++;
      if (TICK !== exp) $display("FAIL periodic_tick n=%0d j=%0d got %b want %b", n, j, TICK, exp);
      else n_pass++;
      if (j == 3 * n) begin
        n_tot++;
        if (TICK_CNT !== 16'd3) $display("FAIL periodic_cnt n=%0d got %0d want 3", n, TICK_CNT);
        else n_pass++;
      end
    end
  endtask

  task automatic test_periodic();
    run_periodic(5);
    for (int r = 0; r < 3; r++) run_periodic(int'($urandom_range(2, 9)));
  endtask

  // Run a active edges, pause for h cycles, resume; the tick needs n-a more active edges.
  task automatic run_pause(input int n, input int a, input int h);
    logic exp;
    to_idle();
    cfg(n, 1'b0);
    START = 1'b1;
    step();
    START = 1'b0;
    for (int j = 1; j <= a; j++) step();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    n_tot++; if (BUSY !== 1'b1) $display("FAIL hold_busy got %b want 1", BUSY); else n_pass++;
    n_tot++; if (CFG_READY !== 1'b0) $display("FAIL hold_ready got %b want 0", CFG_READY);
    else n_pass++;
    for (int j = 0; j < h; j++) begin
      step();
      n_tot++;
      if (TICK !== 1'b0) $display("FAIL hold_tick j=%0d got %b want 0", j, TICK); else n_pass++;
    end
    START = 1'b1;
    step();
    START = 1'b0;
    for (int j = 1; j <= n - a; j++) begin
      step();
      exp = (j == n - a);
      n_tot++;
      if (TICK !== exp) $display("FAIL resume_tick n=%0d a=%0d j=%0d got %b want %b",
                                 n, a, j, TICK, exp);
      else n_pass++;
    end
  endtask

  task automatic test_pause_resume();
    int n;
    run_pause(10, 4, 20);
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(3, 12));
      run_pause(n, int'($urandom_range(1, n - 1)), int'($urandom_range(1, 15)));
    end
  endtask

  task automatic run_oneshot(input int n);
    logic exp;
    to_idle();
    cfg(n, 1'b1);
    START = 1'b1;
    step();
    START = 1'b0;
    for (int j = 1; j <= n; j++) begin
      step();
      exp = (j == n);
      n_tot++;
      if (TICK !== exp) $display("FAIL oneshot_tick j=%0d got %b want %b", j, TICK, exp);
      else n_pass++;
      n_tot++;
      if (DONE !== exp) $display("FAIL oneshot_done j=%0d got %b want %b", j, DONE, exp);
      else n_pass++;
    end
    step();
    n_tot++; if (BUSY !== 1'b0) $display("FAIL oneshot_idle got %b want 0", BUSY); else n_pass++;
    for (int j = 0; j < 20; j++) begin
      step();
      n_tot++;
      if (TICK !== 1'b0 || DONE !== 1'b0)
        $display("FAIL oneshot_quiet j=%0d got %b%b want 00", j, TICK, DONE);
      else n_pass++;
    end
    n_tot++; if (TICK_CNT !== 16'd1) $display("FAIL oneshot_cnt got %0d want 1", TICK_CNT);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    run_oneshot(3);
    run_oneshot(int'($urandom_range(2, 9)));
    // STOP on the terminal count still completes the one-shot.
    to_idle();
    cfg(4, 1'b1);
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    step();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    n_tot++; if (TICK !== 1'b1) $display("FAIL os_stop_tick got %b want 1", TICK); else n_pass++;
    n_tot++; if (DONE !== 1'b1) $display("FAIL os_stop_done got %b want 1", DONE); else n_pass++;
    step();
    n_tot++; if (BUSY !== 1'b0) $display("FAIL os_stop_idle got %b want 0", BUSY); else n_pass++;
  endtask

  task automatic test_config();
    logic exp;
    int n;
    // Offer 7 while running (START also held, which RUN ignores); period stays 5.
    to_idle();
    cfg(5, 1'b0);
    START = 1'b1;
    step();
    step();
    step();
    CFG_VALID = 1'b1;
    CFG_DIV   = CNT_W'(7);
    n_tot++; if (CFG_READY !== 1'b0) $display("FAIL run_ready got %b want 0", CFG_READY);
    else n_pass++;
    for (int j = 3; j <= 15; j++) begin
      step();
      exp = (j % 5 == 0);
      n_tot++;
      if (TICK !== exp) $display("FAIL cfg_in_run j=%0d got %b want %b", j, TICK, exp);
      else n_pass++;
    end
    START     = 1'b0;
    CFG_VALID = 1'b0;
    CFG_DIV   = '0;
    // Period 0 or 1 is stored as 2.
    for (int d = 0; d < 2; d++) begin
      to_idle();
      cfg(d, 1'b0);
      START = 1'b1;
      step();
      START = 1'b0;
      for (int j = 1; j <= 6; j++) begin
        step();
        exp = (j % 2 == 0);
        n_tot++;
        if (TICK !== exp) $display("FAIL cfg_min d=%0d j=%0d got %b want %b", d, j, TICK, exp);
        else n_pass++;
      end
    end
    // Handshake and START on the same edge: the new period applies.
    to_idle();
    n = int'($urandom_range(2, 9));
    CFG_VALID = 1'b1;
    CFG_DIV   = CNT_W'(n);
    START     = 1'b1;
    step();
    CFG_VALID = 1'b0;
    START     = 1'b0;
    for (int j = 1; j <= 2 * n; j++) begin
      step();
      exp = (j % n == 0);
      n_tot++;
      if (TICK !== exp) $display("FAIL cfg_with_start n=%0d j=%0d got %b want %b",
                                 n, j, TICK, exp);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    to_idle();
    cfg(3, 1'b0);
    START = 1'b1;
    step();
    START = 1'b0;
    for (int j = 1; j <= 7; j++) step();
    n_tot++; if (TICK_CNT !== 16'd2) $display("FAIL sim_cnt got %0d want 2", TICK_CNT);
    else n_pass++;
    START = 1'b1;
    STOP  = 1'b1;
    step();
    n_tot++; if (BUSY !== 1'b1) $display("FAIL sim_run_hold got %b want 1", BUSY); else n_pass++;
    n_tot++; if (CFG_READY !== 1'b0) $display("FAIL sim_hold_ready got %b want 0", CFG_READY);
    else n_pass++;
    step();
    n_tot++; if (BUSY !== 1'b0) $display("FAIL sim_hold_idle got %b want 0", BUSY); else n_pass++;
    n_tot++; if (TICK_CNT !== 16'd2) $display("FAIL sim_cnt_hold got %0d want 2", TICK_CNT);
    else n_pass++;
    step();
    n_tot++; if (BUSY !== 1'b0) $display("FAIL sim_idle_stay got %b want 0", BUSY); else n_pass++;
    START = 1'b0;
    STOP  = 1'b0;
  endtask

  task automatic test_clr_midrun();
    logic exp;
    to_idle();
    cfg(6, 1'b0);
    START = 1'b1;
    step();
    START = 1'b0;
    for (int j = 1; j <= 5; j++) step();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    n_tot++; if (TICK !== 1'b0) $display("FAIL clr_tick got %b want 0", TICK); else n_pass++;
    n_tot++; if (BUSY !== 1'b0) $display("FAIL clr_busy got %b want 0", BUSY); else n_pass++;
    n_tot++; if (TICK_CNT !== 16'd0) $display("FAIL clr_cnt got %0d want 0", TICK_CNT);
    else n_pass++;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int j = 1; j <= DEF_DIV + 1; j++) begin
      step();
      exp = (j == DEF_DIV);
      n_tot++;
      if (TICK !== exp) $display("FAIL clr_def_period j=%0d got %b want %b", j, TICK, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_pause_resume();
    test_oneshot();
    test_config();
    test_simultaneous();
    test_clr_midrun();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/timebase_ctrl.md
TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

Interface
REQ-001 SHALL provide parameter CNT_W, default 28, meaning divider count width.
REQ-002 SHALL provide parameter DEF_DIV, default 100000000, meaning reset-time period in clock cycles, giving a 1 Hz tick from 100 MHz.
REQ-003 SHALL provide port CLK_100MHz, input, width 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL provide port CLR, input, width 1: reset, synchronous and active-high.
REQ-005 SHALL provide port CFG_VALID, input, width 1: a new period is offered.
REQ-006 SHALL provide port CFG_READY, output, width 1: a period can be accepted.
REQ-007 SHALL provide port CFG_DIV, input, width CNT_W: requested period N in cycles.
REQ-008 SHALL provide port CFG_ONESHOT, input, width 1: mode bit captured with CFG_DIV; 1 means one tick, then stop.
REQ-009 SHALL provide port START, input, width 1: a level sampled each cycle that starts or resumes counting.
REQ-010 SHALL provide port STOP, input, width 1: a level sampled each cycle that pauses, or aborts when already paused.
REQ-011 SHALL provide port TICK, output, width 1: a one-cycle pulse once per period.
REQ-012 SHALL provide port DONE, output, width 1: a one-cycle pulse when a one-shot completes.
REQ-013 SHALL provide port BUSY, output, width 1: high in RUN or HOLD.
REQ-014 SHALL provide port TICK_CNT, output, width 16: ticks since the last start from IDLE; wraps 0xFFFF to 0.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and HOLD.
REQ-016 SHALL assert CFG_READY only in IDLE; a config handshake completes when CFG_VALID and CFG_READY are both 1.
REQ-017 SHALL capture CFG_DIV and CFG_ONESHOT on handshake; CFG_DIV values 0 or 1 are stored as 2.
REQ-018 SHALL leave the stored period unchanged while CFG_VALID is high outside IDLE; no handshake occurs.
REQ-019 SHALL, when CFG handshake and START coincide in IDLE, apply the new period to that start.
REQ-020 SHALL, when START is sampled in IDLE, go to RUN, clear the counter to 0 and clear TICK_CNT.
REQ-021 SHALL, in RUN, increment the counter each cycle through 0..N-1 and then wrap to 0.
REQ-022 SHALL drive TICK registered and high for exactly the one cycle after the counter is N-1.
REQ-023 SHALL place the first TICK high in cycle k+N after the START sampling edge k, with period exactly N thereafter.
REQ-024 SHALL increment TICK_CNT in the same cycle TICK is high.
REQ-025 SHALL, when STOP is sampled in RUN, go to HOLD with the counter frozen and no TICK; a TICK already registered still completes.
REQ-026 SHALL, when START is sampled in HOLD, resume RUN from the frozen count, so the remaining cycles to the next tick are preserved.
REQ-027 SHALL, when STOP is sampled in HOLD, go to IDLE and clear the counter; TICK_CNT holds its value.
REQ-028 SHALL give STOP priority when START and STOP are both high: RUN goes to HOLD, HOLD goes to IDLE, IDLE stays in IDLE.
REQ-029 SHALL ignore START in RUN.
REQ-030 SHALL, in one-shot mode, on the cycle TICK is high, pulse DONE in the same cycle and return to IDLE the next cycle.
REQ-031 SHALL, if STOP coincides with the one-shot terminal count, still issue TICK and DONE and go to IDLE.
REQ-032 SHALL derive BUSY combinationally from the state.

Reset
REQ-033 SHALL, while CLR is high at an edge, force state IDLE, counter 0, TICK 0, DONE 0 and TICK_CNT 0.
REQ-034 SHALL reset the stored period to DEF_DIV and the mode to periodic.
REQ-035 SHALL abort any RUN or HOLD on CLR with no TICK or DONE emitted.
REQ-036 SHALL give CLR priority over all other inputs.

Structure
REQ-037 SHALL place the state type, CNT_W and DEF_DIV defaults, and the minimum period 2 in shared package timebase_pkg.
REQ-038 SHALL instantiate one sub-module, div_counter: a CNT_W-bit counter with sync clear, enable and terminal-count compare that flags count == N-1.
REQ-039 SHALL keep the FSM, handshake and TICK_CNT logic in timebase_ctrl.

Verification
REQ-040 SHALL test periodic mode: CFG_DIV=5 handshake, then START for 1 cycle -> TICK at k+5, k+10, k+15; TICK_CNT=3 after the third tick.
REQ-041 SHALL test pause/resume: N=10, STOP at the 4th RUN cycle, HOLD for 20 cycles, then START -> the next TICK arrives exactly 6 RUN cycles after resume.
REQ-042 SHALL test one-shot: CFG_DIV=3 with CFG_ONESHOT=1, then START -> a single TICK with DONE in the same cycle, IDLE after, no further TICK for 20 cycles.
REQ-043 SHALL test config rules: CFG_VALID in RUN with CFG_DIV=7 -> CFG_READY=0 and period unchanged; CFG_DIV=0 in IDLE -> period 2.
REQ-044 SHALL test simultaneous events: START and STOP high in RUN -> HOLD; both high in HOLD -> IDLE with BUSY=0.
REQ-045 SHALL test reset mid-run: CLR one cycle before the expected TICK -> no TICK, BUSY=0, TICK_CNT=0, and the period reverts to DEF_DIV.
